fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the combinational 128x8 instruction ROM. Owns the program counter and drives the ROM address. Registers each returned byte into an instruction register with a valid/ready handshake to decode. Handles start, branch redirect/flush, backpressure stall and halt-opcode detection.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 25 ++
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int          FETCH_ADDR_W  = 7;
   localparam int          FETCH_DATA_W  = 8;
   localparam logic [7:0]  FETCH_HALT_OP = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: async clear to RST_VAL, load has priority over increment,
// increment wraps naturally at 2^ADDR_W.
module pc_reg #(
   parameter int                ADDR_W  = 7,
   parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_val,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_pc
);

   logic [ADDR_W-1:0] r_pc;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)    r_pc <= RST_VAL;
      else if (i_load) r_pc <= i_load_val;
      else if (i_inc)  r_pc <= r_pc + ADDR_W'(1);
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, registers ROM bytes into a
// valid/ready instruction register, handles redirect, stall and halt.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int                ADDR_W      = FETCH_ADDR_W,
   parameter int                DATA_W      = FETCH_DATA_W,
   parameter logic [ADDR_W-1:0] START_ADDR  = '0,
   parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(FETCH_HALT_OP)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              start_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              ready_i,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic              done_o
);

   fetch_state_e      r_state;
   logic [DATA_W-1:0] r_instr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic              r_valid;
   logic              r_done;

   logic              w_in_fetch;
   logic              w_start;
   logic              w_redirect;
   logic              w_capture;
   logic              w_halt_hit;
   logic              w_pc_load;
   logic [ADDR_W-1:0] w_pc_load_val;
   logic [ADDR_W-1:0] w_pc;

   assign w_in_fetch = (r_state == ST_FETCH);
   assign w_start    = start_i && !w_in_fetch;
   assign w_redirect = redirect_i && w_in_fetch;
   // Redirect wins over both capture and halt detection in the same cycle.
   assign w_capture  = w_in_fetch && !redirect_i && (!r_valid || ready_i);
   assign w_halt_hit = w_capture && (rom_data_i == HALT_OPCODE);

   assign w_pc_load     = w_start || w_redirect;
   assign w_pc_load_val = w_redirect ? target_i : START_ADDR;

   pc_reg #(
      .ADDR_W  (ADDR_W),
      .RST_VAL (START_ADDR)
   ) u_pc (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .i_load     (w_pc_load),
      .i_load_val (w_pc_load_val),
      .i_inc      (w_capture && !w_halt_hit),
      .o_pc       (w_pc)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_instr    <= '0;
         r_instr_pc <= '0;
         r_valid    <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: begin
               r_valid <= 1'b0;
               if (start_i) begin
                  r_state <= ST_FETCH;
                  r_done  <= 1'b0;
               end
            end
            ST_FETCH: begin
               if (redirect_i) begin
                  r_valid <= 1'b0;
               end else if (w_halt_hit) begin
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_HALT;
               end else if (w_capture) begin
                  r_instr    <= rom_data_i;
                  r_instr_pc <= w_pc;
                  r_valid    <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rom_addr_o = w_pc;
   assign instr_o    = r_instr;
   assign instr_pc_o = r_instr_pc;
   assign valid_o    = r_valid;
   assign busy_o     = w_in_fetch;
   assign done_o     = r_done;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: identity ROM 0..9 (rest 0xFF) on the main
// instance, constant-0x11 ROM on a second instance starting at 126.
module tb_fetch_ctrl;

   localparam int AW = 7;
   localparam int DW = 8;

   typedef struct {
      logic          st;
      logic          rd;
      logic [AW-1:0] tg;
      logic          rdy;
      logic          v;
      logic [DW-1:0] ins;
      logic [AW-1:0] ipc;
      logic [AW-1:0] addr;
      logic          dn;
      logic          bsy;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, redirect, ready;
   logic [AW-1:0] target;
   logic [DW-1:0] rom_data;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          valid, busy, done;

   logic          start2;
   logic [AW-1:0] rom_addr2, instr_pc2;
   logic [DW-1:0] instr2;
   logic          valid2, busy2, done2;

   logic [DW-1:0] rom_mem [128];

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   assign rom_data = rom_mem[rom_addr];

   fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(7'd0), .HALT_OPCODE(8'hFF)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .redirect_i(redirect),
      .target_i(target), .ready_i(ready), .rom_data_i(rom_data),
      .rom_addr_o(rom_addr), .instr_o(instr), .instr_pc_o(instr_pc),
      .valid_o(valid), .busy_o(busy), .done_o(done)
   );

   fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(7'd126), .HALT_OPCODE(8'hFF)) dut2 (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start2), .redirect_i(1'b0),
      .target_i(7'd0), .ready_i(1'b1), .rom_data_i(8'h11),
      .rom_addr_o(rom_addr2), .instr_o(instr2), .instr_pc_o(instr_pc2),
      .valid_o(valid2), .busy_o(busy2), .done_o(done2)
   );

   task automatic add(input logic st, input logic rd, input int tg, input logic rdy,
                      input logic v, input int ins, input int ipc, input int addr,
                      input logic dn, input logic bsy);
      vec_t t;
      t.st = st; t.rd = rd; t.tg = AW'(tg); t.rdy = rdy;
      t.v = v; t.ins = DW'(ins); t.ipc = AW'(ipc); t.addr = AW'(addr);
      t.dn = dn; t.bsy = bsy;
      vecs.push_back(t);
   endtask

   task automatic check_out(input string name, input logic v, input logic [DW-1:0] ins,
                            input logic [AW-1:0] ipc, input logic [AW-1:0] addr,
                            input logic dn, input logic bsy);
      checks++;
      if ({valid, instr, instr_pc, rom_addr, done, busy} !== {v, ins, ipc, addr, dn, bsy}) begin
         errors++;
         $display("FAIL %s: got v=%0b instr=%h pc=%0d addr=%0d done=%0b busy=%0b, want v=%0b instr=%h pc=%0d addr=%0d done=%0b busy=%0b",
                  name, valid, instr, instr_pc, rom_addr, done, busy, v, ins, ipc, addr, dn, bsy);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) rom_mem[i] = (i < 10) ? DW'(i) : 8'hFF;
      start = 0; redirect = 0; ready = 0; target = '0; start2 = 0;
      rst_n = 0;
      #12;
      check_out("reset", 0, 8'h00, 0, 0, 0, 0);
      rst_n = 1;
      step();

      // st rd tg rdy | v ins ipc addr done busy
      add(1,0,0,1, 0,0,0,0,0,1);
      for (int k = 1; k <= 10; k++) add(0,0,0,1, 1,k-1,k-1,k,0,1);
      add(0,0,0,1, 0,9,9,10,1,0);      // halt byte at 10
      add(1,0,0,1, 0,9,9,0,0,1);       // restart from HALT
      add(0,0,0,1, 1,0,0,1,0,1);
      add(0,0,0,1, 1,1,1,2,0,1);
      add(0,0,0,1, 1,2,2,3,0,1);
      add(0,0,0,1, 1,3,3,4,0,1);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 1,3,3,4,0,1);   // stall
      add(0,0,0,1, 1,4,4,5,0,1);
      add(0,1,2,1, 0,4,4,2,0,1);
      add(0,0,0,0, 1,2,2,3,0,1);
      add(0,1,5,0, 0,2,2,5,0,1);       // redirect under stall
      add(0,0,0,0, 1,5,5,6,0,1);
      add(1,0,0,1, 1,6,6,7,0,1);       // start ignored in FETCH
      add(0,1,10,1, 0,6,6,10,0,1);
      add(0,1,3,1, 0,6,6,3,0,1);       // redirect beats halt byte
      add(0,0,0,1, 1,3,3,4,0,1);
      add(0,1,10,1, 0,3,3,10,0,1);
      add(0,0,0,1, 0,3,3,10,1,0);
      add(0,1,4,1, 0,3,3,10,1,0);      // redirect ignored in HALT
      add(1,0,0,1, 0,3,3,0,0,1);
      add(0,0,0,1, 1,0,0,1,0,1);
      add(0,0,0,1, 1,1,1,2,0,1);

      foreach (vecs[i]) begin
         start = vecs[i].st; redirect = vecs[i].rd; target = vecs[i].tg; ready = vecs[i].rdy;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].ins, vecs[i].ipc,
                   vecs[i].addr, vecs[i].dn, vecs[i].bsy);
      end

      // Asynchronous reset between edges.
      start = 0; redirect = 0; ready = 1;
      #2;
      rst_n = 0;
      #1;
      check_out("async_rst", 0, 8'h00, 0, 0, 0, 0);
      step();
      #2 rst_n = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_out($sformatf("idle_after_rst%0d", k), 0, 8'h00, 0, 0, 0, 0);
      end

      // Second instance: wrap from 126 through 0 with no halt.
      start2 = 1;
      step();
      start2 = 0;
      for (int k = 0; k < 4; k++) begin
         logic [AW-1:0] exp_pc;
         exp_pc = AW'(126 + k);
         step();
         checks++;
         if (!(valid2 === 1'b1 && instr2 === 8'h11 && instr_pc2 === exp_pc &&
               done2 === 1'b0 && busy2 === 1'b1)) begin
            errors++;
            $display("FAIL wrap%0d: got v=%0b instr=%h pc=%0d done=%0b busy=%0b, want v=1 instr=11 pc=%0d done=0 busy=1",
                     k, valid2, instr2, instr_pc2, done2, busy2, exp_pc);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
